// File: rtl/sum_seq_pkg.sv
// ---------------------------------------------------------------------------
// sum_seq_pkg
//   Shared definitions for the serial summing sequencer:
//   - default sizing (operand count, operand width, result width)
//   - FSM state encoding (IDLE / ACCUM / DONE)
//   - index width helper for the operand counter
// ---------------------------------------------------------------------------
package sum_seq_pkg;

  localparam int DEF_N_OPS = 8;
  localparam int DEF_OP_W  = 4;
  localparam int DEF_SUM_W = 7;

  // Operand index width for the default configuration.
  localparam int IDX_W = $clog2(DEF_N_OPS);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Counter width for an arbitrary operand count (never below one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_seq_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter, purely combinational. The pointer (last)
//   is owned by the parent; this block only decides the winner.
//   Ports:
//     req  [1:0]  request vector
//     last        requester granted most recently (ties go to the other one)
//     en          arbitration enable; gnt is all-zero when low
//     gnt  [1:0]  one-hot grant
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      // Requester 0 wins when alone, or on a tie when requester 1 went last.
      if (req[0] && (!req[1] || last)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/sum_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sum_seq_ctrl
//   Sequencer for a shared serial summing datapath. Two requesters present
//   packed operand buses; a round-robin arbiter picks one while idle, its
//   operands are copied into a shadow register, and one operand per cycle
//   is added into an accumulator. The result is published with a one-cycle
//   done pulse and held until the next result.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     req0/req1         level requests, sampled only while idle
//     ops0/ops1         packed operands, op[i] = opsX[i*OP_W +: OP_W]
//     grant0/grant1     one-cycle pulse after the winner's operands are latched
//     busy              high while accumulating and during the done cycle
//     done              one-cycle pulse, sum/done_id valid
//     done_id           requester that owns the published sum
//     sum               result, modulo 2^SUM_W
// ---------------------------------------------------------------------------
module sum_seq_ctrl
  import sum_seq_pkg::*;
#(
  parameter int N_OPS = DEF_N_OPS,
  parameter int OP_W  = DEF_OP_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic [N_OPS*OP_W-1:0]  ops0,
  input  logic                   req1,
  input  logic [N_OPS*OP_W-1:0]  ops1,
  output logic                   grant0,
  output logic                   grant1,
  output logic                   busy,
  output logic                   done,
  output logic                   done_id,
  output logic [SUM_W-1:0]       sum
);

  localparam int            IW       = idx_width(N_OPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OPS - 1);

  state_t           state_q, state_d;
  logic [1:0]       gnt;
  logic             arb_en;
  logic             take_job;
  logic             acc_step;
  logic             last_step;

  logic [OP_W-1:0]  ops0_w   [N_OPS];
  logic [OP_W-1:0]  ops1_w   [N_OPS];
  logic [OP_W-1:0]  shadow_q [N_OPS];

  logic [IW-1:0]    idx_q;
  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_sum;
  logic             owner_q;
  logic             last_q;
  logic             grant0_q, grant1_q;
  logic             done_q, done_id_q;
  logic [SUM_W-1:0] sum_q;

  // Unpack operand buses into per-operand views.
  genvar gi;
  generate
    for (gi = 0; gi < N_OPS; gi++) begin : g_unpack
      assign ops0_w[gi] = ops0[gi*OP_W +: OP_W];
      assign ops1_w[gi] = ops1[gi*OP_W +: OP_W];
    end
  endgenerate

  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (last_q),
    .en   (arb_en),
    .gnt  (gnt)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt != 2'b00)     state_d = ST_ACCUM;
      ST_ACCUM: if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs / datapath controls ----
  always_comb begin
    arb_en    = (state_q == ST_IDLE);
    take_job  = (gnt != 2'b00);        // gnt can only be set while idle
    acc_step  = (state_q == ST_ACCUM);
    last_step = (state_q == ST_ACCUM) && (idx_q == LAST_IDX);
    busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  end

  // Zero-extended add of the current shadow operand.
  assign acc_sum = acc_q + SUM_W'(shadow_q[idx_q]);

  // Shadow copy, so operand bus changes after the grant have no effect.
  generate
    for (gi = 0; gi < N_OPS; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q[gi] <= '0;
        end else if (take_job) begin
          shadow_q[gi] <= gnt[1] ? ops1_w[gi] : ops0_w[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      idx_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
    end else begin
      grant0_q <= gnt[0];
      grant1_q <= gnt[1];
      done_q   <= last_step;
      if (take_job) begin
        acc_q   <= '0;
        idx_q   <= '0;
        owner_q <= gnt[1];
        last_q  <= gnt[1];
      end else if (acc_step) begin
        acc_q <= acc_sum;
        idx_q <= idx_q + 1'b1;
      end
      // Publish on the final add so sum is valid alongside done.
      if (last_step) begin
        sum_q     <= acc_sum;
        done_id_q <= owner_q;
      end
    end
  end

  assign grant0  = grant0_q;
  assign grant1  = grant1_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
module tb_sum_seq_ctrl;
  localparam int N_OPS = 8;
  localparam int OP_W  = 4;
  localparam int SUM_W = 7;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req0 = 1'b0, req1 = 1'b0;
  logic [N_OPS*OP_W-1:0] ops0 = '0, ops1 = '0;
  logic                  grant0, grant1, busy, done, done_id;
  logic [SUM_W-1:0]      sum;

  sum_seq_ctrl #(.N_OPS(N_OPS), .OP_W(OP_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .ops0(ops0), .req1(req1), .ops1(ops1),
    .grant0(grant0), .grant1(grant1), .busy(busy),
    .done(done), .done_id(done_id), .sum(sum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sum of packed operands, modulo 2^SUM_W.
  function automatic int sum_ops(input logic [N_OPS*OP_W-1:0] v);
    int s = 0;
    for (int i = 0; i < N_OPS; i++) s += int'(v[i*OP_W +: OP_W]);
    return s % (1 << SUM_W);
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  // A job is described by the edge it was granted on; everything else is
  // timeline arithmetic relative to that edge.
  bit m_active = 0;
  bit m_last   = 1;
  bit m_owner  = 0;
  int m_start  = 0;
  int m_jsum   = 0;
  int m_sum    = 0;
  bit m_id     = 0;

  initial begin
    bit s_rst, s_r0, s_r1;
    logic [N_OPS*OP_W-1:0] s_o0, s_o1;
    bit e_g0, e_g1, e_busy, e_done;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      s_rst = rst; s_r0 = req0; s_r1 = req1; s_o0 = ops0; s_o1 = ops1;
      @(negedge clk);
      if (s_rst) begin
        m_active = 0; m_last = 1; m_sum = 0; m_id = 0;
      end else begin
        // Job occupies grant..done cycles plus one idle edge that does not sample.
        if (m_active && cyc > m_start + N_OPS + 1) m_active = 0;
        if (!m_active && (s_r0 || s_r1)) begin
          m_owner  = (s_r0 && s_r1) ? !m_last : s_r1;
          m_last   = m_owner;
          m_start  = cyc;
          m_active = 1;
          m_jsum   = sum_ops(m_owner ? s_o1 : s_o0);
        end
      end
      e_g0   = m_active && cyc == m_start && !m_owner;
      e_g1   = m_active && cyc == m_start && m_owner;
      e_busy = m_active && cyc <= m_start + N_OPS;
      e_done = m_active && cyc == m_start + N_OPS;
      if (e_done) begin m_sum = m_jsum; m_id = m_owner; end
      chk($sformatf("cyc%0d grant0", cyc), int'(grant0), int'(e_g0));
      chk($sformatf("cyc%0d grant1", cyc), int'(grant1), int'(e_g1));
      chk($sformatf("cyc%0d busy", cyc), int'(busy), int'(e_busy));
      chk($sformatf("cyc%0d done", cyc), int'(done), int'(e_done));
      chk($sformatf("cyc%0d done_id", cyc), int'(done_id), int'(m_id));
      chk($sformatf("cyc%0d sum", cyc), int'(sum), m_sum);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ev(input int which);
    case (which)
      0: return grant0;
      1: return grant1;
      2: return done;
      default: return grant0 | grant1;
    endcase
  endfunction

  task automatic wait_ev(input int which, input int limit, input string name, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (ev(which)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++;
      bad++;
      $display("FAIL %s: no event within %0d cycles, required one", name, limit);
    end
  endtask

  task automatic count_ev(input int which, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (ev(which)) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    int g, d, t0, cnt, prev_d;
    int exp_id[3];
    int exp_sum[3];
    exp_id = '{0, 1, 0};
    exp_sum = '{36, 60, 36};

    // 1: reset
    rst = 1'b1;
    repeat (3) step();
    chk("t1 grant0", int'(grant0), 0);
    chk("t1 grant1", int'(grant1), 0);
    chk("t1 busy", int'(busy), 0);
    chk("t1 done", int'(done), 0);
    chk("t1 done_id", int'(done_id), 0);
    chk("t1 sum", int'(sum), 0);
    rst = 1'b0;
    step();
    $display("t1 reset outputs checked");

    // 2: req0 with all-ones operands
    ops0 = 32'h1111_1111; req0 = 1'b1; t0 = cyc;
    wait_ev(0, 5, "t2 grant0", g);
    req0 = 1'b0;
    chk("t2 grant latency", g - t0, 1);
    wait_ev(2, 20, "t2 done", d);
    chk("t2 done latency", d - g, N_OPS);
    chk("t2 sum", int'(sum), 8);
    chk("t2 done_id", int'(done_id), 0);
    $display("t2 req0 sum=%0d id=%0d", sum, done_id);

    // 3: req1 with max operands, bus cleared after grant
    ops1 = 32'hFFFF_FFFF; req1 = 1'b1;
    wait_ev(1, 6, "t3 grant1", g);
    ops1 = '0; req1 = 1'b0;
    wait_ev(2, 20, "t3 done", d);
    chk("t3 sum", int'(sum), 120);
    chk("t3 done_id", int'(done_id), 1);
    $display("t3 req1 sum=%0d id=%0d", sum, done_id);

    // 4: both requesting after reset -> 0,1,0
    rst = 1'b1; step(); rst = 1'b0;
    ops0 = 32'h1234_5678; ops1 = 32'h0F0F_0F0F;
    req0 = 1'b1; req1 = 1'b1;
    prev_d = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ev(3, 6, "t4 grant", g);
      chk($sformatf("t4 grant%0d owner", k), int'(grant1), exp_id[k]);
      if (k > 0) chk($sformatf("t4 gap%0d", k), g - prev_d, 2);
      if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
      wait_ev(2, 20, "t4 done", d);
      chk($sformatf("t4 done_id%0d", k), int'(done_id), exp_id[k]);
      chk($sformatf("t4 sum%0d", k), int'(sum), exp_sum[k]);
      $display("t4 job%0d id=%0d sum=%0d", k, done_id, sum);
      prev_d = d;
    end

    // 5: req1 pulse inside ACCUM is ignored; held into IDLE is served
    ops0 = 32'h2222_2222; ops1 = 32'h4444_4444; req0 = 1'b1;
    wait_ev(0, 6, "t5 grant0", g);
    req0 = 1'b0;
    repeat (3) step();
    req1 = 1'b1;
    repeat (2) step();
    req1 = 1'b0;
    wait_ev(2, 20, "t5 done", d);
    chk("t5 sum", int'(sum), 16);
    count_ev(1, 6, cnt);
    chk("t5 ignored grant1 count", cnt, 0);
    $display("t5 pulse ignored grant1s=%0d", cnt);
    req0 = 1'b1;
    wait_ev(0, 6, "t5b grant0", g);
    req0 = 1'b0;
    req1 = 1'b1;
    wait_ev(2, 20, "t5b done", d);
    wait_ev(1, 5, "t5b grant1", g);
    req1 = 1'b0;
    chk("t5b gap", g - d, 2);
    wait_ev(2, 20, "t5b done1", d);
    chk("t5b sum", int'(sum), 32);
    chk("t5b done_id", int'(done_id), 1);
    $display("t5 held req1 sum=%0d id=%0d", sum, done_id);

    // 6: reset in 4th ACCUM cycle aborts the job
    ops0 = 32'h3333_3333; req0 = 1'b1;
    wait_ev(0, 6, "t6 grant0", g);
    req0 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 busy", int'(busy), 0);
    chk("t6 done", int'(done), 0);
    chk("t6 sum", int'(sum), 0);
    chk("t6 done_id", int'(done_id), 0);
    count_ev(2, 12, cnt);
    chk("t6 aborted done count", cnt, 0);
    ops0 = 32'h8765_4321; req0 = 1'b1; t0 = cyc;
    wait_ev(0, 6, "t6b grant0", g);
    req0 = 1'b0;
    chk("t6b grant latency", g - t0, 1);
    wait_ev(2, 20, "t6b done", d);
    chk("t6b done latency", d - g, N_OPS);
    chk("t6b sum", int'(sum), 36);
    chk("t6b done_id", int'(done_id), 0);
    $display("t6 after abort sum=%0d id=%0d", sum, done_id);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
